// File: rtl/rr_mux_4_1_arb_if.sv
// Handshake bundle for rr_mux_4_1_arb: four request/data sources, the
// one-hot ack back to them, and the registered valid/ready output.
interface rr_mux_4_1_arb_if #(
  parameter int CNT_W = 16
);
  logic [3:0] req;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] ack;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] out_sel;
`ifdef RR_MUX_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] grant_cnt;
`endif

  modport master (
    output req, d0, d1, d2, d3, out_ready,
    input  ack, out_valid, out_data, out_sel
`ifdef RR_MUX_ARB_GRANT_CNT_EN
    , input grant_cnt
`endif
  );

  modport slave (
    input  req, d0, d1, d2, d3, out_ready,
    output ack, out_valid, out_data, out_sel
`ifdef RR_MUX_ARB_GRANT_CNT_EN
    , output grant_cnt
`endif
  );
endinterface

// File: rtl/rr_mux_4_1_arb.sv
// rr_mux_4_1_arb: round-robin (or fixed-priority) 4:1 arbiter driving a
// mux_4_1 select and capturing the winner into a 1-entry valid/ready reg.
// Ports: clk, rst_n (async active-low), bus (slave modport: req, d0..d3,
// ack, out_valid, out_ready, out_data, out_sel, grant_cnt when enabled).
// Params: PRIO_FIXED (0 = round-robin, 1 = fixed, src 0 highest), CNT_W.
// Optional grant counter: define RR_MUX_ARB_GRANT_CNT_EN.

module mux_4_1 (
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [1:0] sel,
  output logic [3:0] y
);
  always_comb begin
    y = d0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
    endcase
  end
endmodule

module rr_mux_4_1_arb #(
  parameter bit PRIO_FIXED = 1'b0,
  parameter int CNT_W      = 16
) (
  input logic             clk,
  input logic             rst_n,
  rr_mux_4_1_arb_if.slave bus
);
  logic [3:0] req;
  logic [3:0] ack;
  logic [3:0] y;
  logic [3:0] data_q;
  logic [1:0] sel_q;
  logic       valid_q;
  logic [1:0] last_q;
  logic [1:0] rr_gidx;
  logic [1:0] fp_gidx;
  logic [1:0] gidx;
  logic [1:0] idx;
  logic       can_load;

  assign req      = bus.req;
  assign can_load = !valid_q || bus.out_ready;

  // Walk from last+4 down to last+1 so the nearest requester after the
  // pointer is the final (winning) assignment.
  always_comb begin
    rr_gidx = '0;
    idx     = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_q + 2'(k);
      if (req[idx]) rr_gidx = idx;
    end
  end

  always_comb begin
    fp_gidx = '0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) fp_gidx = 2'(i);
    end
  end

  assign gidx = PRIO_FIXED ? fp_gidx : rr_gidx;

  mux_4_1 u_mux (
    .d0  (bus.d0),
    .d1  (bus.d1),
    .d2  (bus.d2),
    .d3  (bus.d3),
    .sel (gidx),
    .y   (y)
  );

  // rst_n gates ack so sources never see a consume while held in reset.
  always_comb begin
    ack = '0;
    if (rst_n && can_load && |req) ack[gidx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 2'd3;
    end else if (|ack) begin
      data_q  <= y;
      sel_q   <= gidx;
      valid_q <= 1'b1;
      last_q  <= gidx;
    end else if (can_load && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef RR_MUX_ARB_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else if (|ack) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign bus.grant_cnt = cnt_q;
`endif

  assign bus.ack       = ack;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
endmodule

// File: tb/tb_rr_mux_4_1_arb.sv
// Directed bench for rr_mux_4_1_arb: reset, round-robin walk, stall,
// drain+load, fixed priority, and grant counter when enabled.
module tb_rr_mux_4_1_arb;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_mux_4_1_arb_if #(.CNT_W(2)) rr_if ();
  rr_mux_4_1_arb_if #(.CNT_W(2)) fp_if ();

  rr_mux_4_1_arb #(.PRIO_FIXED(1'b0), .CNT_W(2)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rr_if.slave)
  );

  rr_mux_4_1_arb #(.PRIO_FIXED(1'b1), .CNT_W(2)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (fp_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] rr_exp [5];
    rr_exp = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst_n = 1'b1;
    rr_if.req = 4'hF;
    rr_if.d0 = 4'h1;
    rr_if.d1 = 4'h2;
    rr_if.d2 = 4'h3;
    rr_if.d3 = 4'h4;
    rr_if.out_ready = 1'b1;
    fp_if.req = 4'h0;
    fp_if.d0 = 4'h0;
    fp_if.d1 = 4'h0;
    fp_if.d2 = 4'h0;
    fp_if.d3 = 4'h0;
    fp_if.out_ready = 1'b1;

    // reset held with all requests up
    #1 rst_n = 1'b0;
    tick;
    tick;
    chk("rst_valid", 16'(rr_if.out_valid), 16'h0);
    chk("rst_data", 16'(rr_if.out_data), 16'h0);
    chk("rst_sel", 16'(rr_if.out_sel), 16'h0);
    chk("rst_ack", 16'(rr_if.ack), 16'h0);
    chk("rst_fp_valid", 16'(fp_if.out_valid), 16'h0);

    // round-robin walk
    rst_n = 1'b1;
    #1;
    chk("rr_ack0", 16'(rr_if.ack), 16'h1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rr_data", 16'(rr_if.out_data), 16'(rr_exp[i]));
      chk("rr_sel", 16'(rr_if.out_sel), 16'(i % 4));
      chk("rr_valid", 16'(rr_if.out_valid), 16'h1);
      chk("rr_ack", 16'(rr_if.ack), 16'(1 << ((i + 1) % 4)));
    end

    // stall
    rr_if.req = 4'b0100;
    rr_if.d2 = 4'hA;
    #1;
    chk("st_ack_load", 16'(rr_if.ack), 16'h4);
    tick;
    chk("st_data", 16'(rr_if.out_data), 16'hA);
    chk("st_sel", 16'(rr_if.out_sel), 16'h2);
    rr_if.out_ready = 1'b0;
    rr_if.req = 4'b0011;
    #1;
    chk("st_ack0", 16'(rr_if.ack), 16'h0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("st_hold_data", 16'(rr_if.out_data), 16'hA);
      chk("st_hold_sel", 16'(rr_if.out_sel), 16'h2);
      chk("st_hold_valid", 16'(rr_if.out_valid), 16'h1);
      chk("st_hold_ack", 16'(rr_if.ack), 16'h0);
    end
    rr_if.out_ready = 1'b1;
    #1;
    chk("st_rel_ack", 16'(rr_if.ack), 16'h1);
    tick;
    chk("st_rel_sel", 16'(rr_if.out_sel), 16'h0);
    chk("st_rel_data", 16'(rr_if.out_data), 16'h1);

    // drain and load in the same cycle
    rr_if.req = 4'b1000;
    rr_if.d3 = 4'h7;
    #1;
    chk("dl_valid_pre", 16'(rr_if.out_valid), 16'h1);
    chk("dl_ack", 16'(rr_if.ack), 16'h8);
    tick;
    chk("dl_data", 16'(rr_if.out_data), 16'h7);
    chk("dl_valid", 16'(rr_if.out_valid), 16'h1);
    chk("dl_sel", 16'(rr_if.out_sel), 16'h3);
    rr_if.req = 4'h0;
    tick;
    chk("drain_valid", 16'(rr_if.out_valid), 16'h0);
    chk("drain_data_hold", 16'(rr_if.out_data), 16'h7);

    // fixed priority
    fp_if.req = 4'b1010;
    fp_if.d1 = 4'h5;
    fp_if.d3 = 4'h9;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_ack", 16'(fp_if.ack), 16'h2);
      tick;
      chk("fp_sel", 16'(fp_if.out_sel), 16'h1);
      chk("fp_data", 16'(fp_if.out_data), 16'h5);
      chk("fp_valid", 16'(fp_if.out_valid), 16'h1);
    end
    fp_if.req = 4'h0;

    // counter stream and mid-stream reset
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    rr_if.req = 4'hF;
    rr_if.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("cs_valid", 16'(rr_if.out_valid), 16'h1);
      chk("cs_sel", 16'(rr_if.out_sel), 16'(i % 4));
`ifdef RR_MUX_ARB_GRANT_CNT_EN
      chk("cnt", 16'(rr_if.grant_cnt), 16'((i + 1) % 4));
`endif
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(rr_if.out_valid), 16'h0);
    chk("mid_rst_data", 16'(rr_if.out_data), 16'h0);
    chk("mid_rst_ack", 16'(rr_if.ack), 16'h0);
`ifdef RR_MUX_ARB_GRANT_CNT_EN
    chk("mid_rst_cnt", 16'(rr_if.grant_cnt), 16'h0);
`endif
    rst_n = 1'b1;
    #1;
    chk("ptr_rst_ack", 16'(rr_if.ack), 16'h1);
    tick;
    chk("ptr_rst_sel", 16'(rr_if.out_sel), 16'h0);
    chk("ptr_rst_data", 16'(rr_if.out_data), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rr_mux_4_1_arb.md
Name: rr_mux_4_1_arb

Overview:
- Sequential stage directly upstream of and wrapping the team's 4-bit mux_4_1.
- Four 4-bit sources raise requests. The block arbitrates among them, round-robin by default.
- It drives the 2-bit select of a mux_4_1 instance and captures the selected word into a single-entry valid/ready output register.
- The output feeds the downstream consumer.

Parameters:
- PRIO_FIXED, 0, arbitration mode: 0 = round-robin, 1 = fixed priority with source 0 highest.
- CNT_W, 16, width of the optional grant counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  per-source request; bit i means d_i holds valid data.
- d0, d1, d2, d3  input  4 each  source data words.
- ack  output  4  one-hot, combinational; bit i means d_i is consumed at this edge.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word.
- out_data  output  4  registered word.
- out_sel  output  2  registered index of the source of out_data.
- grant_cnt  output  CNT_W  present only with the optional feature.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer last=3, so the first search starts at source 0.
  - grant_cnt=0.
  - ack is 0 while in reset.
- Load enable: can_load = !out_valid | out_ready. A drain and a load in the same cycle are allowed, giving full throughput of one word per cycle.
- Grant selection (combinational):
  - Round-robin mode: search order is last+1, last+2, last+3, last+4, all mod 4. The first index with req set wins.
  - Fixed-priority mode: the lowest set index wins; last is ignored.
- Grant index gidx drives the sel input of the mux_4_1 instance. Its y output is the capture data.
- ack = onehot(gidx) when can_load and |req; otherwise ack=0.
- Capture on the clock edge when ack is nonzero:
  - out_data <= y, out_sel <= gidx, out_valid <= 1, last <= gidx.
- Clock edge with can_load, out_ready and no request: out_valid <= 0. out_data and out_sel hold their values.
- While out_valid && !out_ready (stall):
  - out_data, out_sel and out_valid are stable.
  - ack=0 and last is unchanged.
  - Requests may change freely; sources must hold d_i and req_i until acked.
- Latency: request to out_valid is 1 cycle when can_load.
- Wrap-around: last=3 means search starts at 0. A single requester repeatedly granted gets one grant per cycle. The pointer never skips a requester; every source with req held high is granted within 4 loads.
- Reset asserted mid-transfer: the held word is discarded and out_valid drops immediately. The pointer returns to 3.

Optional Feature:
- Macro: RR_MUX_ARB_GRANT_CNT_EN.
- Defined:
  - grant_cnt port exists. It is a CNT_W-bit counter incremented on every capture edge (ack nonzero).
  - It wraps modulo 2^CNT_W and is cleared by reset.
- Undefined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset check: hold rst_n=0 with req=4'hF. Expect out_valid=0, out_data=0, out_sel=0, ack=0. Release; next edge expect out_sel=0, out_data=d0.
- Round-robin fairness: req=4'hF held, out_ready=1, d0..d3=4'h1,4'h2,4'h3,4'h4. Consecutive out_data must be 1,2,3,4,1; ack must walk 0001,0010,0100,1000.
- Stall: load d2=4'hA (req=4'b0100), then out_ready=0 for 3 cycles with req=4'b0011. Expect out_data=A, out_sel=2, ack=0 throughout. On out_ready=1, next word comes from source 0 or 1 per pointer order, i.e. 0 after last=2 wrap via 3.
- Simultaneous drain and load: out_valid=1, out_ready=1, req=4'b1000, d3=4'h7. Expect ack=1000 in the same cycle and out_data=7 with out_valid still 1 next cycle (no bubble).
- Fixed priority (PRIO_FIXED=1): req=4'b1010 held for 3 loads. Expect out_sel=1 every time and ack[3] never asserted.
- Counter (macro defined, CNT_W=2): perform 5 captures. Expect grant_cnt=1,2,3,0,1. Assert rst_n=0 mid-stream; expect grant_cnt=0 and out_valid=0 asynchronously.
